// File: rtl/mem_bus_rr_arbiter.sv
// mem_bus_rr_arbiter: shares one bus master port between N_REQ requesters, routes responses by ID FIFO (ARB_FIXED_PRIO_EN = fixed priority).
// Latency: req->bus_req/gnt and bus_r_valid->r_valid are combinational, zero cycles.
// Backpressure: bus_req_o is held low while MAX_OUTST transactions are unanswered; requesters hold until gnt_o.

module mem_bus_id_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_rdy,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop_rdy) rd_ptr <= nxt(rd_ptr);
            case ({push_vld, pop_rdy})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module mem_bus_rr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int MAX_OUTST  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_REQ-1:0]                     req_i,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     add_i,
    input  logic [N_REQ-1:0]                     wen_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
    input  logic [N_REQ-1:0][BE_WIDTH-1:0]       be_i,
    output logic [N_REQ-1:0]                     gnt_o,
    output logic [N_REQ-1:0]                     r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 bus_req_o,
    output logic [ADDR_WIDTH-1:0]                bus_add_o,
    output logic                                 bus_wen_o,
    output logic [DATA_WIDTH-1:0]                bus_wdata_o,
    output logic [BE_WIDTH-1:0]                  bus_be_o,
    input  logic                                 bus_gnt_i,
    input  logic                                 bus_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                bus_r_rdata_i,
    output logic                                 err_o
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [IW-1:0] win;
    logic [IW-1:0] head;
    logic [CW-1:0] cnt;
    logic          req_any;
    logic          accept;
    logic          pop;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) win = IW'(i);
        end
    end
`else
    logic [IW-1:0] ptr;

    // Walk the rotated order backwards so the entry closest to ptr is written last.
    always_comb begin
        win = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr) + k) % N_REQ]) win = IW'((int'(ptr) + k) % N_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr <= '0;
        else if (accept) ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
    end
`endif

    assign req_any   = |req_i;
    // No bypass: a pop in the same cycle does not open a slot while full.
    assign bus_req_o = req_any && (cnt < CW'(MAX_OUTST));
    assign accept    = bus_req_o && bus_gnt_i;
    assign pop       = bus_r_valid_i && (cnt != '0);

    assign bus_add_o   = req_any ? add_i[win]   : '0;
    assign bus_wen_o   = req_any ? wen_i[win]   : 1'b0;
    assign bus_wdata_o = req_any ? wdata_i[win] : '0;
    assign bus_be_o    = req_any ? be_i[win]    : '0;
    assign r_rdata_o   = bus_r_rdata_i;

    always_comb begin
        gnt_o     = '0;
        r_valid_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt_o[i]     = accept && (win == IW'(i));
            r_valid_o[i] = pop && (head == IW'(i));
        end
    end

    mem_bus_id_fifo #(
        .W     (IW),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (accept),
        .push_dat (win),
        .pop_rdy  (pop),
        .head_dat (head),
        .cnt      (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         err_o <= 1'b0;
        else if (bus_r_valid_i && cnt == '0) err_o <= 1'b1;
    end
endmodule

// File: tb/tb_mem_bus_rr_arbiter.sv
// Randomized and directed bench for mem_bus_rr_arbiter against a queue-based reference model.
module tb_mem_bus_rr_arbiter;
    localparam int N   = 4;
    localparam int AW  = 13;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int MAX = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           req_i;
    logic [N-1:0][AW-1:0]   add_i;
    logic [N-1:0]           wen_i;
    logic [N-1:0][DW-1:0]   wdata_i;
    logic [N-1:0][BW-1:0]   be_i;
    logic [N-1:0]           gnt_o;
    logic [N-1:0]           r_valid_o;
    logic [DW-1:0]          r_rdata_o;
    logic                   bus_req_o;
    logic [AW-1:0]          bus_add_o;
    logic                   bus_wen_o;
    logic [DW-1:0]          bus_wdata_o;
    logic [BW-1:0]          bus_be_o;
    logic                   bus_gnt_i;
    logic                   bus_r_valid_i;
    logic [DW-1:0]          bus_r_rdata_i;
    logic                   err_o;

    mem_bus_rr_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_OUTST(MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o), .bus_req_o(bus_req_o), .bus_add_o(bus_add_o),
        .bus_wen_o(bus_wen_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_gnt_i(bus_gnt_i), .bus_r_valid_i(bus_r_valid_i),
        .bus_r_rdata_i(bus_r_rdata_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding requester IDs, their bus response data, rr pointer, error flag, memory.
    int             mq[$];
    logic [DW-1:0]  bq[$];
    int             mptr;
    bit             merr;
    logic [DW-1:0]  mem [int];
    int             last_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        req_i = '0; add_i = '0; wen_i = '0; wdata_i = '0; be_i = '0;
    endtask

    task automatic set_req(input int i, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] b);
        req_i[i] = 1'b1; wen_i[i] = w; add_i[i] = a; wdata_i[i] = d; be_i[i] = b;
    endtask

    task automatic resp(input bit v);
        bus_r_valid_i = v && (mq.size() > 0);
        bus_r_rdata_i = bus_r_valid_i ? bq[0] : DW'($urandom);
    endtask

    function automatic int pick();
        int w = -1;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) if (req_i[i]) w = i;
`else
        for (int k = 0; k < N; k++) if (w < 0 && req_i[(mptr + k) % N]) w = (mptr + k) % N;
`endif
        return w;
    endfunction

    // Called just after a falling edge with inputs driven; checks all outputs, advances one clock.
    task automatic cycle();
        int w; bit breq, acc, pop;
        logic [N-1:0] eg, er;
        #1;
        w    = pick();
        breq = (w >= 0) && (mq.size() < MAX);
        acc  = breq && bus_gnt_i;
        pop  = bus_r_valid_i && (mq.size() > 0);
        eg   = acc ? (N'(1) << w) : '0;
        er   = pop ? (N'(1) << mq[0]) : '0;
        chk("bus_req", bus_req_o, breq);
        chk("gnt", gnt_o, eg);
        chk("r_valid", r_valid_o, er);
        chk("r_rdata", r_rdata_o, bus_r_rdata_i);
        chk("bus_add", bus_add_o, (w >= 0) ? add_i[w] : '0);
        chk("bus_wen", bus_wen_o, (w >= 0) ? wen_i[w] : 1'b0);
        chk("bus_wdata", bus_wdata_o, (w >= 0) ? wdata_i[w] : '0);
        chk("bus_be", bus_be_o, (w >= 0) ? be_i[w] : '0);
        chk("err", err_o, merr);
        if (pop) begin
            void'(mq.pop_front());
            void'(bq.pop_front());
        end
        if (bus_r_valid_i && !pop) merr = 1'b1;
        last_w = acc ? w : -1;
        if (acc) begin
            mq.push_back(w);
            bq.push_back(wen_i[w] ? '0 : (mem.exists(int'(add_i[w])) ? mem[int'(add_i[w])] : '0));
            if (wen_i[w]) mem[int'(add_i[w])] = wdata_i[w];
            mptr = (w + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_req();
        bus_gnt_i = 1'b0; bus_r_valid_i = 1'b0; bus_r_rdata_i = '0;
        mq.delete(); bq.delete(); mptr = 0; merr = 1'b0;
        #1;
        chk("rst_err", err_o, 1'b0);
        chk("rst_bus_req", bus_req_o, 1'b0);
        chk("rst_gnt", gnt_o, '0);
        chk("rst_r_valid", r_valid_o, '0);
        chk("rst_bus_add", bus_add_o, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < MAX + 1; k++) begin
            if (mq.size() == 0) break;
            clear_req(); bus_gnt_i = 1'b0; resp(1'b1);
            cycle();
        end
    endtask

    initial begin
        bit            pend [N];
        logic [N-1:0]  prev;
        rst_n = 1'b0;
        clear_req();
        bus_gnt_i = 1'b0; bus_r_valid_i = 1'b0; bus_r_rdata_i = '0;
        @(negedge clk);
        chk("init_r_rdata", r_rdata_o, '0);
        chk("init_bus_wdata", bus_wdata_o, '0);
        chk("init_bus_be", bus_be_o, '0);
        chk("init_bus_wen", bus_wen_o, 1'b0);
        do_reset();

`ifndef ARB_FIXED_PRIO_EN
        // Single requester store, then its response, then ptr must sit at 3.
        set_req(2, 1'b1, 13'h00fe, 32'hdea0bee0, 4'hf); bus_gnt_i = 1'b1; resp(1'b0);
        #1;
        chk("single_gnt", gnt_o, 4'b0100);
        chk("single_add", bus_add_o, 13'h00fe);
        cycle();
        clear_req(); bus_gnt_i = 1'b0; resp(1'b1);
        #1;
        chk("single_rvalid", r_valid_o, 4'b0100);
        cycle();
        req_i = 4'b1111; bus_gnt_i = 1'b1; resp(1'b0);
        #1;
        chk("single_ptr3", gnt_o, 4'b1000);
        cycle();
        drain();

        // Round-robin with every requester active and single-cycle responses.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, i[0], AW'($urandom), DW'($urandom), BW'($urandom));
        bus_gnt_i = 1'b1;
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            resp(1'b1);
            #1;
            chk("rr_order", gnt_o, N'(1) << (k % N));
            chk("rr_rvalid", r_valid_o, prev);
            prev = N'(1) << (k % N);
            cycle();
        end
        drain();

        // Load routing: requester 3 stores, requester 1 loads it back.
        clear_req(); set_req(3, 1'b1, 13'h10fe, 32'h12345678, 4'hf); bus_gnt_i = 1'b1; resp(1'b0);
        cycle();
        drain();
        clear_req(); set_req(1, 1'b0, 13'h10fe, '0, 4'hf); bus_gnt_i = 1'b1; resp(1'b0);
        cycle();
        clear_req(); bus_gnt_i = 1'b0; resp(1'b1);
        #1;
        chk("load_rvalid", r_valid_o, 4'b0010);
        chk("load_rdata", r_rdata_o, 32'h12345678);
        cycle();

        // Full stall: two accepts, then no request even while a pop happens.
        do_reset();
        req_i = 4'b0011; bus_gnt_i = 1'b1; resp(1'b0);
        cycle();
        cycle();
        #1;
        chk("full_bus_req", bus_req_o, 1'b0);
        chk("full_gnt", gnt_o, '0);
        cycle();
        resp(1'b1);
        #1;
        chk("full_nobypass", bus_req_o, 1'b0);
        cycle();
        resp(1'b0);
        #1;
        chk("full_freed", bus_req_o, 1'b1);
        cycle();
        drain();

        // Empty pop, then reset with a transaction in flight.
        do_reset();
        bus_r_valid_i = 1'b1; bus_r_rdata_i = 32'h5a5a5a5a;
        #1;
        chk("epop_rvalid", r_valid_o, '0);
        cycle();
        bus_r_valid_i = 1'b0;
        #1;
        chk("epop_err", err_o, 1'b1);
        for (int k = 0; k < 3; k++) cycle();
        set_req(2, 1'b0, 13'h0040, '0, 4'hf); bus_gnt_i = 1'b1;
        cycle();
        do_reset();
        #1;
        chk("post_rst_err", err_o, 1'b0);
        bus_r_valid_i = 1'b1; bus_r_rdata_i = 32'h0;
        cycle();
        bus_r_valid_i = 1'b0;
        req_i = 4'b1111; bus_gnt_i = 1'b1;
        #1;
        chk("post_rst_ptr0", gnt_o, 4'b0001);
        cycle();
        #1;
        chk("post_rst_cnt0", bus_req_o, 1'b1);
        cycle();
        drain();
`else
        req_i = 4'b1010; bus_gnt_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            resp(1'b1);
            #1;
            chk("fixed_gnt", gnt_o, 4'b0010);
            cycle();
        end
        drain();
`endif

        // Randomized traffic with holding requesters and a random bus.
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    set_req(i, 1'($urandom), AW'($urandom_range(15)), DW'($urandom), BW'($urandom));
                end else if (pend[i] && $urandom_range(19) == 0) begin
                    pend[i] = 1'b0;
                    req_i[i] = 1'b0;
                end
            end
            bus_gnt_i = ($urandom_range(3) != 0);
            resp($urandom_range(1) == 1);
            cycle();
            if (last_w >= 0) begin
                pend[last_w] = 1'b0;
                req_i[last_w] = 1'b0;
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_rr_arbiter.md
# mem_bus_rr_arbiter

Round-robin arbiter that shares one master port of the one-master/two-slave memory bus wrap between N_REQ requesters using the same req/gnt/r_valid protocol. It sits between the requesters and the bus master port 0. It picks one requester per cycle and forwards its request. It tracks in-flight transactions in an ID FIFO so that each BRAM response returns to the requester that issued it.

## Interface
- N_REQ, 4: number of requesters (2..8)
- ADDR_WIDTH, 13: bus address width (ADDR_MEM_WIDTH + slave-select bit)
- DATA_WIDTH, 32: data width
- BE_WIDTH, DATA_WIDTH/8: byte-enable width
- MAX_OUTST, 2: maximum accepted-but-unanswered transactions (ID FIFO depth, 1..4)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_i  in  N_REQ  per-requester request
- add_i  in  N_REQ×ADDR_WIDTH  per-requester address
- wen_i  in  N_REQ  per-requester type, 1 = store, 0 = load
- wdata_i  in  N_REQ×DATA_WIDTH  per-requester write data
- be_i  in  N_REQ×BE_WIDTH  per-requester byte enables
- gnt_o  out  N_REQ  one-hot grant
- r_valid_o  out  N_REQ  one-hot response valid
- r_rdata_o  out  DATA_WIDTH  response data, shared by all requesters
- bus_req_o  out  1  request to bus master port
- bus_add_o / bus_wen_o / bus_wdata_o / bus_be_o  out  ADDR_WIDTH / 1 / DATA_WIDTH / BE_WIDTH  muxed request fields
- bus_gnt_i  in  1  bus grant
- bus_r_valid_i  in  1  bus response valid
- bus_r_rdata_i  in  DATA_WIDTH  bus response data
- err_o  out  1  sticky protocol error

## Operation
- State: rr pointer ptr (clog2(N_REQ) bits), ID FIFO (MAX_OUTST entries of requester index), occupancy cnt (0..MAX_OUTST), err flag.
- Winner selection:
  - Winner w is the first index with req_i set, searching ptr, ptr+1, … and wrapping modulo N_REQ.
  - Selection is combinational.
- Request forwarding:
  - bus_req_o = |req_i && cnt < MAX_OUTST.
  - bus_add_o, bus_wen_o, bus_wdata_o and bus_be_o carry requester w's fields. All are 0 when no request is pending.
- gnt_o[w] = bus_req_o && bus_gnt_i. All other grant bits are 0.
- Accept: bus_req_o && bus_gnt_i.
  - Push w into the FIFO.
  - ptr ← (w+1) mod N_REQ.
  - ptr is unchanged when there is no accept.
- Response:
  - Every accepted transaction, load or store, yields exactly one bus_r_valid_i.
  - On bus_r_valid_i with cnt>0: pop the head h and assert r_valid_o[h] in the same cycle.
  - r_rdata_o = bus_r_rdata_i always.
- Simultaneous push and pop: cnt is unchanged; FIFO order is preserved.
- Full: cnt==MAX_OUTST forces bus_req_o=0, even when a pop occurs in the same cycle (no bypass).
- Empty pop: bus_r_valid_i with cnt==0 drops the response, asserts no r_valid_o, and sets err_o. err_o clears only on reset.
- Requesters hold req_i and the request fields stable until granted. Deasserting before the grant is allowed and has no side effects.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): ptr=0, cnt=0, FIFO cleared, err_o=0.
  - With req_i=0 and bus_r_valid_i=0, every output is 0.
- Request path is zero latency: req_i → bus_req_o, and bus_gnt_i → gnt_o, are combinational in the same cycle.
- Response path is zero latency: bus_r_valid_i → r_valid_o is combinational. End-to-end load latency equals bus latency (1 cycle with the BRAM wrap).
- Back-to-back: one accept per cycle is sustained while cnt<MAX_OUTST and responses return every cycle.
- Reset mid-operation: in-flight FIFO entries are discarded. Responses arriving after reset release are empty pops and set err_o.

## Configuration
- ARB_FIXED_PRIO_EN defined: fixed priority. The lowest set index in req_i wins, and ptr is not implemented.
- ARB_FIXED_PRIO_EN undefined: round-robin as described in Operation.

## Test plan
- Single requester:
  - Stimulus: after reset, req_i=4'b0100 store to add 13'h00fe with wdata 32'hdea0bee0, bus_gnt_i=1.
  - Response: gnt_o=4'b0100 the same cycle, bus_add_o=13'h00fe; after the bus response, r_valid_o=4'b0100 and ptr=3.
- Round-robin:
  - Stimulus: req_i=4'b1111 held for 8 cycles, bus granting every cycle, 1-cycle responses.
  - Response: grant order 0,1,2,3,0,1,2,3; each r_valid_o one-hot matches the grant from one cycle earlier.
- Load routing:
  - Stimulus: requester 1 loads 13'h10fe (slave 1) after another master stored 32'h12345678 there.
  - Response: r_valid_o=4'b0010 with r_rdata_o=32'h12345678.
- Full stall:
  - Stimulus: MAX_OUTST=2, bus withholds bus_r_valid_i, req_i=4'b0011.
  - Response: two accepts, then bus_req_o=0 and gnt_o=0; the first response frees a slot one cycle later.
- Empty pop and reset:
  - Stimulus: bus_r_valid_i pulsed with cnt=0, then rst_n low for 1 cycle mid-transfer.
  - Response: err_o=1 sticky, no r_valid_o; after reset err_o=0, cnt=0, ptr=0.
- Fixed priority (ARB_FIXED_PRIO_EN defined):
  - Stimulus: req_i=4'b1010 held.
  - Response: requester 1 is granted every cycle; requester 3 is never granted.
